// File: rtl/hex_field.sv
// hex_field: two-stage overlay that renders a DIGITS-wide hex value as ASCII
// codes at a fixed character cell on the VGA text grid. The video stream
// passes through unchanged with the same 2-cycle latency as char_code.
// Optional leading-zero blanking is enabled by defining HEX_FIELD_LZB_EN.

// Nibble to uppercase ASCII hex digit.
module hex_field_nib2asc (
  input  logic [3:0] nib,
  output logic [7:0] asc
);
  // 0..9 -> '0'..'9', A..F -> 'A'..'F'
  always_comb begin
    asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  end
endmodule

module hex_field #(
  parameter int DIGITS  = 4,
  parameter int COL     = 9,
  parameter int ROW     = 8,
  parameter int ZOOM    = 2,
  parameter int FRAME_Y = 480
) (
  input  logic                  px_clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  value_valid,
  input  logic [25:0]           RGBStr_i,
  output logic [25:0]           RGBStr_o,
  output logic [7:0]            char_code,
  output logic                  pending
);
  localparam int VW = 4 * DIGITS;
  localparam int SH = 3 + ZOOM;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [25:0]   str;
    logic          in_field;
    logic [IW-1:0] idx;
  } s1_t;

  logic [9:0]  x, y, col, row;
  logic        av, commit;
  logic        in_field_c;
  logic [IW-1:0] idx_c;
  s1_t         s1;

  logic [VW-1:0] shadow_r, disp_r, disp_nxt;
  logic          disp_ld;
  logic [DIGITS-1:0][7:0] asc;
  logic          show;

  assign x   = RGBStr_i[22:13];
  assign y   = RGBStr_i[12:3];
  assign av  = RGBStr_i[0];
  assign col = x >> SH;
  assign row = y >> SH;

  // Commit point is the first pixel of the first blanking line.
  assign commit = (x == 10'd0) && (y == 10'(FRAME_Y));

  // Field hit test and digit index for the stage-1 register.
  always_comb begin
    in_field_c = av && (row == 10'(ROW)) && (col >= 10'(COL)) &&
                 ({1'b0, col} < 11'(COL + DIGITS));
    idx_c      = IW'(col - 10'(COL));
  end

  // Next displayed value: a same-cycle load bypasses the shadow register.
  always_comb begin
    disp_ld  = 1'b0;
    disp_nxt = shadow_r;
    if (commit) begin
      if (value_valid) begin
        disp_ld  = 1'b1;
        disp_nxt = value_i;
      end else if (pending) begin
        disp_ld  = 1'b1;
      end
    end
  end

`ifdef HEX_FIELD_LZB_EN
  // Blank mask indexed like idx (0 = MSD); the LSD is never blanked.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [VW-1:0] v);
    logic run;
    lzb_mask = '0;
    run      = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      run = run && (v[4*(DIGITS-1-k) +: 4] == 4'h0);
      lzb_mask[k] = run && (k != DIGITS - 1);
    end
  endfunction

  logic [DIGITS-1:0] blank_r;

  // Mask is recomputed only when the displayed value changes.
  always_ff @(posedge px_clk) begin
    if (reset)        blank_r <= lzb_mask('0);
    else if (disp_ld) blank_r <= lzb_mask(disp_nxt);
  end

  assign show = !blank_r[s1.idx];
`else
  assign show = 1'b1;
`endif

  // Shadow, displayed value and pending flag.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      shadow_r <= '0;
      disp_r   <= '0;
      pending  <= 1'b0;
    end else begin
      if (value_valid) shadow_r <= value_i;
      if (disp_ld)     disp_r   <= disp_nxt;
      if (commit)           pending <= 1'b0;
      else if (value_valid) pending <= 1'b1;
    end
  end

  // One encoder per digit; asc[g] belongs to idx g (g = 0 is the MSD).
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    hex_field_nib2asc u_nib (
      .nib (disp_r[4*(DIGITS-1-g) +: 4]),
      .asc (asc[g])
    );
  end

  // Stage 1: register stream with hit flag and digit index.
  always_ff @(posedge px_clk) begin
    if (reset) s1 <= '0;
    else       s1 <= '{str: RGBStr_i, in_field: in_field_c, idx: idx_c};
  end

  // Stage 2: select digit glyph code and register the aligned stream.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      RGBStr_o  <= '0;
      char_code <= 8'h00;
    end else begin
      RGBStr_o  <= s1.str;
      char_code <= (s1.in_field && show) ? asc[s1.idx] : 8'h00;
    end
  end
endmodule

// File: tb/tb_hex_field.sv
// Bench for hex_field (DIGITS=4, COL=9, ROW=8, ZOOM=2). Expected outputs are
// queued at drive time and compared two cycles later.
module tb_hex_field;
  logic        px_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] value_i = '0;
  logic        value_valid = 1'b0;
  logic [25:0] RGBStr_i = '0;
  logic [25:0] RGBStr_o;
  logic [7:0]  char_code;
  logic        pending;

  hex_field #(.DIGITS(4), .COL(9), .ROW(8), .ZOOM(2), .FRAME_Y(480)) dut (
    .px_clk(px_clk), .reset(reset), .value_i(value_i), .value_valid(value_valid),
    .RGBStr_i(RGBStr_i), .RGBStr_o(RGBStr_o), .char_code(char_code), .pending(pending)
  );

  always #5 px_clk = ~px_clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [33:0] q[$];
  logic [15:0] m_disp = '0, m_sh = '0;
  logic        m_pend = 1'b0;
  string       hx = "0123456789ABCDEF";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] mk(input int x, input int y, input bit av);
    logic [25:0] s;
    s = {3'b101, 10'(x), 10'(y), 1'b0, 1'b0, av};
    return s;
  endfunction

  function automatic logic [7:0] model_char(input logic [25:0] s);
    int col, row, idx;
    logic [3:0] nib;
    logic [3:0] blank;
    bit run;
    col = int'(s[22:13]) / 32;
    row = int'(s[12:3]) / 32;
    if (!s[0] || row != 8 || col < 9 || col > 12) return 8'h00;
    idx = col - 9;
    nib = 4'((m_disp >> (4 * (3 - idx))) & 16'hF);
    blank = '0;
`ifdef HEX_FIELD_LZB_EN
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run = run && (((m_disp >> (12 - 4 * k)) & 16'hF) == 0);
      blank[k] = run;
    end
`else
    run = 1'b0;
`endif
    if (blank[idx]) return 8'h00;
    return hx[nib];
  endfunction

  // One clock: check outputs for the step driven two cycles ago, then drive.
  task automatic cyc(input bit r, input bit vv, input logic [15:0] v,
                     input logic [25:0] s, input int exp_char);
    logic [33:0] e;
    logic [7:0]  ch;
    @(negedge px_clk);
    chk("pending", 32'(pending), 32'(m_pend));
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("stream", 32'(RGBStr_o), 32'(e[33:8]));
      chk("char", 32'(char_code), 32'(e[7:0]));
    end
    reset = r; value_valid = vv; value_i = v; RGBStr_i = s;
    if (r) begin
      m_disp = '0; m_sh = '0; m_pend = 1'b0;
      foreach (q[i]) q[i] = '0;
      q.push_back('0);
    end else begin
      if (vv) m_sh = v;
      if (s[22:13] == 10'd0 && s[12:3] == 10'd480) begin
        if (vv) m_disp = v;
        else if (m_pend) m_disp = m_sh;
        m_pend = 1'b0;
      end else if (vv) begin
        m_pend = 1'b1;
      end
      ch = (exp_char >= 0) ? 8'(exp_char) : model_char(s);
      q.push_back({s, ch});
    end
  endtask

  task automatic px(input int x, input int y, input int exp_char);
    cyc(1'b0, 1'b0, 16'h0, mk(x, y, 1'b1), exp_char);
  endtask

  initial begin
    logic [25:0] s;
    q.push_back('0);
    q.push_back('0);
    // reset
    cyc(1, 0, 16'h0, mk(300, 256, 1), -1);
    cyc(1, 0, 16'h0, mk(300, 256, 1), -1);
    // load 0xBEEF and commit
    cyc(0, 1, 16'hBEEF, mk(5, 470, 0), -1);
    cyc(0, 0, 16'h0, mk(6, 470, 0), -1);
    cyc(0, 0, 16'h0, mk(0, 480, 0), -1);
    px(288, 256, 8'h42);
    px(320, 256, 8'h45);
    px(352, 256, 8'h45);
    px(415, 256, 8'h46);
    px(287, 256, 8'h00);
    px(416, 256, 8'h00);
    px(288, 255, 8'h00);
    px(288, 288, 8'h00);
    cyc(0, 0, 16'h0, mk(300, 256, 0), 8'h00);
    // mid-frame load stays pending until the commit line
    cyc(0, 1, 16'h1234, mk(100, 300, 1), 8'h00);
    px(288, 256, 8'h42);
    px(400, 479, 8'h00);
    cyc(0, 0, 16'h0, mk(0, 480, 0), -1);
    px(288, 256, 8'h31);
    px(320, 256, 8'h32);
    px(352, 256, 8'h33);
    px(384, 256, 8'h34);
    // load on the commit cycle bypasses to the display
    cyc(0, 1, 16'h00A5, mk(0, 480, 0), -1);
`ifdef HEX_FIELD_LZB_EN
    px(288, 256, 8'h00); px(320, 256, 8'h00);
`else
    px(288, 256, 8'h30); px(320, 256, 8'h30);
`endif
    px(352, 256, 8'h41);
    px(384, 256, 8'h35);
    // random stream, biased toward the field, with occasional loads/commits
    for (int i = 0; i < 1000; i++) begin
      s = 26'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        s[22:13] = 10'($urandom_range(250, 450));
        s[12:3]  = 10'($urandom_range(240, 300));
      end
      if (i % 100 == 99) begin
        s[22:13] = 10'd0;
        s[12:3]  = 10'd480;
      end
      cyc(0, ($urandom_range(0, 49) == 0), 16'($urandom), s, -1);
    end
    // reset mid-line inside the field with a load pending
    cyc(0, 1, 16'h7777, mk(320, 256, 1), -1);
    cyc(1, 0, 16'h0, mk(330, 256, 1), -1);
    px(300, 256, -1);
`ifdef HEX_FIELD_LZB_EN
    px(288, 256, 8'h00);
    px(416, 256, 8'h00);
    px(384, 256, 8'h30);
`else
    px(288, 256, 8'h30);
    px(416, 256, 8'h00);
    px(384, 256, 8'h30);
`endif
    // drain
    cyc(0, 0, 16'h0, mk(1, 1, 0), -1);
    cyc(0, 0, 16'h0, mk(2, 1, 0), -1);
    cyc(0, 0, 16'h0, mk(3, 1, 0), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_field.md
Name: hex_field

Overview:
- Pipelined overlay stage that renders a multi-digit hexadecimal value as ASCII character codes at a fixed character-cell position on the VGA text grid.
- Sits between vga_sync (via the 26-bit RGB stream) and the font module. Consumes the stream and emits it delayed, with a matching char_code.
- Generalises the hand-coded 2-digit counter display: digit count, position and zoom are parameters.
- Displayed value is committed only in vertical blanking, so a frame never shows a torn value.

Parameters:
- DIGITS, 4, number of hex digits shown (1..8); value width is 4*DIGITS.
- COL, 9, character column of the leftmost (most significant) digit, in zoomed cells.
- ROW, 8, character row of the field, in zoomed cells.
- ZOOM, 2, log2 pixel zoom; cell size is 2^(3+ZOOM) pixels.
- FRAME_Y, 480, stream y value at which a pending value is committed (first blanking line).

Ports:
- px_clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- value_i  in  4*DIGITS  value to display.
- value_valid  in  1  one-cycle load strobe for value_i.
- RGBStr_i  in  26  stream: [25:23] rgb, [22:13] x, [12:3] y, [2] hsync, [1] vsync, [0] activevideo.
- RGBStr_o  out  26  RGBStr_i delayed by exactly 2 cycles, bit-identical.
- char_code  out  8  ASCII code for the pixel carried on RGBStr_o; 0x00 outside the field.
- pending  out  1  high while a loaded value is waiting for commit.

Behaviour:
- Reset (synchronous, active-high): RGBStr_o=0, char_code=0x00, pending=0, shadow and displayed registers=0. Pipeline is flushed, so outputs are 0 for the 2 cycles after reset deasserts regardless of input.
- Load: value_valid=1 captures value_i into shadow and sets pending. A second strobe before commit overwrites shadow; the last one wins.
- Commit: fires on the cycle RGBStr_i has x==0 and y==FRAME_Y. If pending, copy shadow into displayed and clear pending.
- Load and commit in the same cycle: value_i bypasses straight into displayed, and pending ends 0.
- If not pending at commit, displayed is unchanged.
- Stage 1 (registered):
  - col = x>>(3+ZOOM), row = y>>(3+ZOOM).
  - in_field = activevideo && row==ROW && COL <= col < COL+DIGITS.
  - idx = col-COL, computed at the width needed to hold DIGITS-1.
  - Stream is registered alongside.
- Stage 2 (registered):
  - Nibble = displayed[4*(DIGITS-1-idx) +: 4], so idx 0 is the MSD.
  - 0..9 map to 0x30..0x39; A..F map to 0x41..0x46 (uppercase).
  - char_code = in_field ? ascii : 0x00.
  - Stream is registered again to form RGBStr_o.
- Latency: exactly 2 px_clk for both char_code and RGBStr_o; they are always aligned.
- Column/row comparisons are unsigned; x/y values beyond the visible area never match the field unless the arithmetic places them there. Wrap-around of col is not possible at 10 bits.
- Commit lands in blanking, so the displayed value is stable through every active line of a frame.

Optional Feature:
- Macro HEX_FIELD_LZB_EN (leading-zero blanking).
- When defined: at commit, compute and register a DIGITS-bit blank mask. Digit i is blanked if it and all more-significant digits are 0. The least-significant digit is never blanked. In stage 2, a blanked digit outputs char_code 0x00.
- When undefined: no mask logic; every digit is always shown.

Test Plan:
- DIGITS=4, COL=9, ROW=8, ZOOM=2. Load 0xBEEF, step stream to x=0,y=480. Then active x=288,y=256 → 2 cycles later char_code=0x42. x=320 → 0x45. x=415 → 0x46. x=287 and x=416 → 0x00. pending goes 1→0 at commit.
- Load 0x1234 mid-frame at y=300 → display stays 0xBEEF through y=479 and pending=1. After x=0,y=480, the next frame shows 0x31,0x32,0x33,0x34.
- value_valid with 0x00A5 on the exact commit cycle → pending stays 0; next frame shows 0x30,0x30,0x41,0x35. With HEX_FIELD_LZB_EN it shows 0x00,0x00,0x41,0x35.
- HEX_FIELD_LZB_EN with value 0x0000 → 0x00,0x00,0x00,0x30.
- Random stream for 1000 cycles → RGBStr_o equals RGBStr_i from 2 cycles earlier. activevideo=0 inside field coordinates → char_code=0x00.
- Assert reset mid-line inside the field → next edge RGBStr_o=0, char_code=0, pending=0. After release, the first 2 outputs are 0, then rendering of value 0x0000 resumes.
